// File: rtl/eprisc_bus_bridge.sv
// Byte-serial host command bridge: collects a command frame, runs one device access, returns status + read data.
// Latency: last command strobe -> device enable next cycle; device ready -> oReady after the following edge.
// Backpressure: host paces bytes with iByteStrobe; a slow device stalls via iDevReady up to TIMEOUT cycles.
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iSelect             frame enable; dropping it aborts the frame and returns to idle
//   iByteStrobe, iMOSI  one-cycle qualified host byte
//   oMISO, oReady       response byte and response-phase flag
//   oInterrupt          OR of the sticky pending interrupt register
//   oDevAddr/WData/Write/Enable   access request to the selected device window
//   iDevRData, iDevReady, iDevIrq per-device read data, completion and interrupt lines
module eprisc_bus_bridge #(
  parameter int ADDR_W        = 15,
  parameter int WDATA_W       = 16,
  parameter int DATA_BYTES    = 4,
  parameter int NUM_DEV       = 4,
  parameter int DEV_SPAN_LOG2 = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iSelect,
  input  logic                           iByteStrobe,
  input  logic [7:0]                     iMOSI,
  output logic [7:0]                     oMISO,
  output logic                           oReady,
  output logic                           oInterrupt,
  output logic [ADDR_W-1:0]              oDevAddr,
  output logic [WDATA_W-1:0]             oDevWData,
  output logic                           oDevWrite,
  output logic [NUM_DEV-1:0]             oDevEnable,
  input  logic [NUM_DEV*8*DATA_BYTES-1:0] iDevRData,
  input  logic [NUM_DEV-1:0]             iDevReady,
  input  logic [NUM_DEV-1:0]             iDevIrq
);

  localparam int CMD_W     = 1 + ADDR_W + WDATA_W;
  localparam int CMD_BYTES = CMD_W / 8;
  localparam int RD_W      = 8 * DATA_BYTES;
  localparam int MAXB      = (CMD_BYTES > DATA_BYTES + 1) ? CMD_BYTES : DATA_BYTES + 1;
  localparam int IDX_W     = $clog2(MAXB + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]         state;
  logic [IDX_W-1:0]   byteIdx;
  logic [15:0]        toutCnt;
  logic [CMD_W-1:0]   cmdReg;
  logic [7:0]         status;
  logic [RD_W-1:0]    rdData;
  logic [NUM_DEV-1:0] pending;

  logic               cmdWrite;
  logic [ADDR_W-1:0]  cmdAddr;
  logic [WDATA_W-1:0] cmdWData;
  logic [ADDR_W-1:0]  devIdxFull;
  logic               isPendAddr;
  logic [NUM_DEV-1:0] devOneHot;
  logic               devHit;
  logic               accessDev;
  logic [RD_W-1:0]    selRData;
  logic               selReady;
  logic [NUM_DEV-1:0] pendClr;
  logic [NUM_DEV-1:0] pendingNext;
  logic [7:0]         respByte;

  assign cmdWrite   = cmdReg[CMD_W-1];
  assign cmdAddr    = cmdReg[CMD_W-2 -: ADDR_W];
  assign cmdWData   = cmdReg[WDATA_W-1:0];
  assign devIdxFull = cmdAddr >> DEV_SPAN_LOG2;
  assign isPendAddr = &cmdAddr;

  // One-hot decode only produces bits for existing windows, so an empty
  // vector doubles as the "index out of range" indication.
  always_comb begin
    devOneHot = '0;
    selRData  = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      devOneHot[k] = (devIdxFull == ADDR_W'(k));
      if (devIdxFull == ADDR_W'(k)) begin
        selRData = iDevRData[k*RD_W +: RD_W];
      end
    end
  end

  assign devHit    = !isPendAddr && (|devOneHot);
  assign accessDev = (state == ST_ACCESS) && devHit;
  assign selReady  = |(iDevReady & devOneHot);

  assign oDevEnable = accessDev ? devOneHot : '0;
  assign oDevAddr   = accessDev ? cmdAddr   : '0;
  assign oDevWData  = accessDev ? cmdWData  : '0;
  assign oDevWrite  = accessDev && cmdWrite;

  // Pending-register access clears in its single ACCESS cycle; new interrupts
  // are OR-ed in after the clear so a simultaneous set survives.
  always_comb begin
    pendClr = '0;
    if ((state == ST_ACCESS) && iSelect && isPendAddr) begin
      pendClr = cmdWrite ? NUM_DEV'(cmdWData) : '1;
    end
    pendingNext = (pending & ~pendClr) | iDevIrq;
  end

  // Response byte 0 is status, bytes 1..DATA_BYTES are read data LSB-first.
  always_comb begin
    respByte = '0;
    if (byteIdx == '0) begin
      respByte = status;
    end
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (byteIdx == IDX_W'(b + 1)) begin
        respByte = rdData[b*8 +: 8];
      end
    end
  end

  assign oReady = (state == ST_RESP);
  assign oMISO  = (state == ST_RESP) ? respByte : 8'h00;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= ST_IDLE;
      byteIdx    <= '0;
      toutCnt    <= '0;
      cmdReg     <= '0;
      status     <= '0;
      rdData     <= '0;
      pending    <= '0;
      oInterrupt <= 1'b0;
    end else begin
      pending    <= pendingNext;
      oInterrupt <= |pendingNext;

      if (!iSelect) begin
        state   <= ST_IDLE;
        byteIdx <= '0;
        toutCnt <= '0;
        status  <= '0;
      end else begin
        case (state)
          // A strobe arriving with the select edge is already byte 0.
          ST_IDLE, ST_CMD: begin
            state <= ST_CMD;
            if (iByteStrobe) begin
              for (int b = 0; b < CMD_BYTES; b++) begin
                if (byteIdx == IDX_W'(b)) begin
                  cmdReg[b*8 +: 8] <= iMOSI;
                end
              end
              if (byteIdx == IDX_W'(CMD_BYTES - 1)) begin
                state   <= ST_ACCESS;
                byteIdx <= '0;
                toutCnt <= '0;
              end else begin
                byteIdx <= byteIdx + 1'b1;
              end
            end
          end

          ST_ACCESS: begin
            if (isPendAddr) begin
              status  <= 8'h01;
              rdData  <= cmdWrite ? '0 : RD_W'(pending);
              state   <= ST_RESP;
              byteIdx <= '0;
            end else if (!devHit) begin
              status  <= 8'h04;
              rdData  <= '0;
              state   <= ST_RESP;
              byteIdx <= '0;
            end else if (selReady) begin
              status  <= 8'h01;
              rdData  <= cmdWrite ? '0 : selRData;
              state   <= ST_RESP;
              byteIdx <= '0;
            end else if (toutCnt == 16'(TIMEOUT - 1)) begin
              status  <= 8'h02;
              rdData  <= '0;
              state   <= ST_RESP;
              byteIdx <= '0;
            end else begin
              toutCnt <= toutCnt + 16'd1;
            end
          end

          ST_RESP: begin
            if (iByteStrobe) begin
              if (byteIdx == IDX_W'(DATA_BYTES)) begin
                state <= ST_DONE;
              end else begin
                byteIdx <= byteIdx + 1'b1;
              end
            end
          end

          ST_DONE: begin
            state <= ST_DONE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eprisc_bus_bridge.sv
// Bench for eprisc_bus_bridge: directed frames from the test plan plus randomized frames.
// Expected response bytes and enable windows are queued at issue time and popped by monitors.
// Device side is emulated with a programmable ready delay (negative = never ready).
module tb_eprisc_bus_bridge;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iSelect;
  logic         iByteStrobe;
  logic [7:0]   iMOSI;
  logic [7:0]   oMISO;
  logic         oReady;
  logic         oInterrupt;
  logic [14:0]  oDevAddr;
  logic [15:0]  oDevWData;
  logic         oDevWrite;
  logic [3:0]   oDevEnable;
  logic [127:0] iDevRData;
  logic [3:0]   iDevReady;
  logic [3:0]   iDevIrq;

  eprisc_bus_bridge dut (
    .iClk(iClk), .iRst(iRst), .iSelect(iSelect), .iByteStrobe(iByteStrobe),
    .iMOSI(iMOSI), .oMISO(oMISO), .oReady(oReady), .oInterrupt(oInterrupt),
    .oDevAddr(oDevAddr), .oDevWData(oDevWData), .oDevWrite(oDevWrite),
    .oDevEnable(oDevEnable), .iDevRData(iDevRData), .iDevReady(iDevReady),
    .iDevIrq(iDevIrq)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [3:0]  oh;
    logic [14:0] addr;
    logic [15:0] wd;
    logic        wr;
    int          len;
    logic        rdyAfter;
  } enExp_t;

  int          checks = 0;
  int          fails  = 0;
  logic [7:0]  respQ[$];
  enExp_t      enQ[$];
  logic [3:0]  pendM = 4'h0;
  logic [31:0] devData[4];
  int          devDelay = -1;
  int          enRuns = 0;
  logic [3:0]  accIrq = 4'h0;

  assign iDevRData = {devData[3], devData[2], devData[1], devData[0]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device emulation: ready asserted in enable cycle number devDelay.
  initial begin
    int cnt;
    cnt = 0;
    iDevReady = 4'h0;
    forever begin
      @(negedge iClk);
      if (oDevEnable != 4'h0) begin
        iDevReady = (devDelay >= 0 && cnt == devDelay) ? oDevEnable : 4'h0;
        cnt++;
      end else begin
        iDevReady = 4'h0;
        cnt = 0;
      end
    end
  end

  // Response monitor: each host strobe during the response phase consumes one byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge iClk);
      if (iByteStrobe && oReady) begin
        if (respQ.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL resp_unexpected: got byte %0h with nothing expected", oMISO);
        end else begin
          e = respQ.pop_front();
          chk("resp_byte", oMISO, e);
        end
      end
    end
  end

  // Enable monitor: measures each contiguous enable window and checks it on close.
  initial begin
    int          len;
    enExp_t      cur;
    logic [3:0]  oh;
    logic [14:0] a;
    logic [15:0] w;
    logic        wr;
    len = 0;
    oh = 0; a = 0; w = 0; wr = 0;
    forever begin
      @(negedge iClk);
      if (oDevEnable != 4'h0) begin
        if (len == 0) begin
          oh = oDevEnable; a = oDevAddr; w = oDevWData; wr = oDevWrite;
        end
        len++;
      end else if (len > 0) begin
        enRuns++;
        if (enQ.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL en_unexpected: enable %0h seen with nothing expected", oh);
        end else begin
          cur = enQ.pop_front();
          chk("en_onehot", oh, cur.oh);
          chk("en_addr", a, cur.addr);
          chk("en_wdata", w, cur.wd);
          chk("en_write", wr, cur.wr);
          chk("en_len", len, cur.len);
          chk("en_then_ready", oReady, cur.rdyAfter);
        end
        len = 0;
      end
    end
  end

  task automatic pulseIrq(input logic [3:0] m);
    iDevIrq = m;
    @(posedge iClk); #1;
    iDevIrq = 4'h0;
    pendM = pendM | m;
    @(negedge iClk);
    chk("irq_pulse", oInterrupt, |pendM);
    @(posedge iClk); #1;
  endtask

  // mode: 0 normal, 1 abort during access, 2 reset during response, 3 irq during access
  task automatic runFrame(input logic wr, input logic [14:0] addr, input logic [15:0] wd,
                          input int delay, input int mode);
    logic [31:0] cmd;
    logic [7:0]  st;
    logic [31:0] data;
    logic [3:0]  oh;
    logic [3:0]  clrMask;
    bit          hasEn;
    int          dev;
    int          runs0;
    int          w;
    int          g;
    int          n;
    enExp_t      e;

    cmd   = {wr, addr, wd};
    dev   = int'(addr >> 8);
    hasEn = 0;
    oh    = 4'h0;
    data  = 32'h0;
    if (addr == 15'h7FFF) begin
      st      = 8'h01;
      data    = wr ? 32'h0 : {28'h0, pendM};
      clrMask = wr ? wd[3:0] : 4'hF;
      pendM   = (pendM & ~clrMask) | accIrq;
    end else if (dev >= 4) begin
      st = 8'h04;
    end else begin
      hasEn = 1;
      oh    = 4'b0001 << dev;
      e.oh = oh; e.addr = addr; e.wd = wd; e.wr = wr; e.rdyAfter = 1'b1;
      if (delay >= 0) begin
        st = 8'h01;
        data = wr ? 32'h0 : devData[dev];
        e.len = delay + 1;
      end else begin
        st = 8'h02;
        e.len = 255;
      end
      if (mode == 1) begin
        e.len = 3;
        e.rdyAfter = 1'b0;
      end
      enQ.push_back(e);
    end
    if (mode != 1) begin
      respQ.push_back(st);
      for (int i = 0; i < 4; i++) respQ.push_back(data[i*8 +: 8]);
    end
    devDelay = delay;
    runs0 = enRuns;

    if ($urandom_range(0, 1) == 1) begin
      iSelect = 1'b1;
      @(posedge iClk); #1;
    end
    for (int b = 0; b < 4; b++) begin
      g = $urandom_range(0, 2);
      if (b > 0) repeat (g) begin @(posedge iClk); #1; end
      iSelect = 1'b1;
      iMOSI = cmd[b*8 +: 8];
      iByteStrobe = 1'b1;
      @(posedge iClk); #1;
      iByteStrobe = 1'b0;
      iMOSI = 8'($urandom);
    end
    if (mode == 3) iDevIrq = accIrq;
    @(negedge iClk);
    chk("en_latency", oDevEnable, hasEn ? oh : 4'h0);
    if (mode == 3) begin
      @(posedge iClk); #1;
      iDevIrq = 4'h0;
    end

    if (mode == 1) begin
      @(negedge iClk);
      @(negedge iClk);
      iSelect = 1'b0;
      @(posedge iClk); #1;
      @(negedge iClk);
      chk("abort_en_off", oDevEnable, 4'h0);
      chk("abort_ready_off", oReady, 1'b0);
      @(posedge iClk); #1;
      chk("abort_runs", enRuns - runs0, 1);
      devDelay = -1;
      return;
    end

    w = 0;
    while (!oReady && w < 600) begin
      @(negedge iClk);
      w++;
    end
    chk("resp_ready", oReady, 1'b1);

    n = (mode == 2) ? 1 : 5;
    for (int i = 0; i < n; i++) begin
      @(posedge iClk); #1;
      iByteStrobe = 1'b1;
      @(posedge iClk); #1;
      iByteStrobe = 1'b0;
    end

    if (mode == 2) begin
      iRst = 1'b1;
      @(posedge iClk); #1;
      iRst = 1'b0;
      @(negedge iClk);
      chk("rst_ready", oReady, 1'b0);
      chk("rst_miso", oMISO, 8'h00);
      chk("rst_irq", oInterrupt, 1'b0);
      chk("rst_en", oDevEnable, 4'h0);
      respQ.delete();
      pendM = 4'h0;
      @(posedge iClk); #1;
    end else begin
      @(posedge iClk); #1;
      iByteStrobe = 1'b1;
      @(negedge iClk);
      chk("done_ready", oReady, 1'b0);
      chk("done_miso", oMISO, 8'h00);
      @(posedge iClk); #1;
      iByteStrobe = 1'b0;
    end
    chk("en_runs", enRuns - runs0, hasEn ? 1 : 0);
    iSelect = 1'b0;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    chk("irq_level", oInterrupt, |pendM);
    devDelay = -1;
    accIrq = 4'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind;
    logic [14:0] addr;
    iRst = 1'b1;
    iSelect = 1'b0;
    iByteStrobe = 1'b0;
    iMOSI = 8'h00;
    iDevIrq = 4'h0;
    for (int k = 0; k < 4; k++) devData[k] = $urandom;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    chk("reset_ready", oReady, 1'b0);
    chk("reset_miso", oMISO, 8'h00);
    chk("reset_irq", oInterrupt, 1'b0);
    chk("reset_en", oDevEnable, 4'h0);
    chk("reset_addr", oDevAddr, 15'h0);
    chk("reset_wdata", oDevWData, 16'h0);
    chk("reset_write", oDevWrite, 1'b0);
    @(posedge iClk); #1;

    // Directed frames
    runFrame(1'b1, 15'h0005, 16'h1234, 1, 0);
    devData[1] = 32'hDEADBEEF;
    runFrame(1'b0, 15'h0105, 16'h0000, 3, 0);
    runFrame(1'b0, 15'h0200, 16'h0000, -1, 0);
    runFrame(1'b0, 15'h0400, 16'h0000, 0, 0);
    runFrame(1'b0, 15'h0105, 16'h0000, -1, 1);
    runFrame(1'b0, 15'h0110, 16'h0000, 2, 0);
    chk("irq_idle", oInterrupt, 1'b0);
    pulseIrq(4'b0100);
    runFrame(1'b0, 15'h7FFF, 16'h0000, 0, 0);
    pulseIrq(4'b0100);
    accIrq = 4'b0100;
    runFrame(1'b1, 15'h7FFF, 16'h0004, 0, 3);
    runFrame(1'b0, 15'h7FFF, 16'h0000, 0, 0);
    pulseIrq(4'b1000);
    runFrame(1'b0, 15'h0003, 16'h0000, 0, 2);
    runFrame(1'b0, 15'h0301, 16'h0000, 0, 0);

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) devData[k] = $urandom;
      if ($urandom_range(0, 3) == 0) pulseIrq(4'($urandom_range(1, 15)));
      kind = $urandom_range(0, 9);
      if (kind <= 6) addr = 15'($urandom_range(0, 3) * 256 + $urandom_range(0, 255));
      else if (kind == 7) addr = 15'($urandom_range(32'h400, 32'h7FFE));
      else addr = 15'h7FFF;
      runFrame(1'($urandom_range(0, 1)), addr, 16'($urandom), $urandom_range(0, 5), 0);
    end

    chk("resp_queue_empty", respQ.size(), 0);
    chk("en_queue_empty", enQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/eprisc_bus_bridge.md
Name: eprisc_bus_bridge

Overview:
- Parametrised, single-clock successor to the v1 byte-serial I/O controller front end.
- Collects a byte-serial command frame from the host bus and decodes it to one of NUM_DEV device windows.
- Runs one access with a ready/timeout handshake, then returns a status byte followed by read data.
- Aggregates device interrupts into a sticky pending register that the host reads and clears through a reserved address.

Parameters:
- ADDR_W, 15: command address width.
- WDATA_W, 16: command write-data width. 1+ADDR_W+WDATA_W must be a multiple of 8; CMD_BYTES = (1+ADDR_W+WDATA_W)/8.
- DATA_BYTES, 4: read-data bytes returned per frame.
- NUM_DEV, 4: device windows, 1..16.
- DEV_SPAN_LOG2, 8: window size is 2^DEV_SPAN_LOG2; device index = addr >> DEV_SPAN_LOG2.
- TIMEOUT, 255: maximum enable cycles without ready, 1..65535.

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iSelect  in  1  frame enable; low aborts the frame
- iByteStrobe  in  1  one-cycle byte qualifier
- iMOSI  in  8  host byte
- oMISO  out  8  response byte
- oReady  out  1  oMISO valid; response phase active
- oInterrupt  out  1  OR of pending interrupts
- oDevAddr  out  ADDR_W  access address (full)
- oDevWData  out  WDATA_W  write data
- oDevWrite  out  1  access is a write
- oDevEnable  out  NUM_DEV  one-hot device enable
- iDevRData  in  NUM_DEV*8*DATA_BYTES  per-device read data; device k occupies slice k
- iDevReady  in  NUM_DEV  per-device access complete
- iDevIrq  in  NUM_DEV  per-device interrupt level/pulse

Behaviour:
- Reset: all outputs 0; state IDLE; counters, command register, pending register cleared.
- Command word: bit MSB = write; next ADDR_W bits = address; low WDATA_W bits = write data. Bytes arrive LSB-first.
- IDLE: iSelect=1 -> CMD. A strobe in the same cycle is captured as byte 0.
- CMD: each strobe with iSelect=1 stores iMOSI at the byte index and increments it. The strobe of byte CMD_BYTES-1 -> ACCESS next cycle.
- ACCESS, checked in priority order:
  - Address all-ones: internal pending register. Status 0x01. Read returns pending zero-extended and clears it in the same cycle. Write clears the bits where wdata=1. Single cycle, no device enable.
  - Device index >= NUM_DEV: status 0x04, data 0, no enable, single cycle.
  - Otherwise: oDevEnable[idx]=1 from the cycle after the last strobe, with oDevAddr, oDevWData and oDevWrite driven. iDevReady[idx] is sampled every edge while enabled. When it is high: capture slice idx on reads (data 0 on writes), status 0x01, drop enable next cycle, go to RESP.
  - Timeout counter counts enabled cycles. At TIMEOUT without ready: drop enable, status 0x02, data 0.
  - Strobes during ACCESS are ignored.
- RESP: oReady=1. oMISO = status first, then data bytes LSB-first. Each strobe advances one byte. The strobe on the last data byte -> DONE.
- DONE: oReady=0, oMISO=0. Wait for iSelect=0 -> IDLE; further strobes are ignored.
- iSelect=0 in any state: IDLE next cycle. oDevEnable=0 next cycle, and an in-flight access result is discarded. Byte index, timeout counter and status are cleared.
- Interrupts: pending |= iDevIrq every cycle (sticky). oInterrupt = |pending, registered (one-cycle latency). If a set and a clear of the same bit happen in the same cycle, the set wins.
- Minimum latency: last command strobe at edge E -> enable high after E; ready high -> oReady high after the next edge.
- A frame with more than CMD_BYTES bytes before the response is not possible; extra strobes fall into ACCESS, RESP or DONE per the rules above.

Test Plan:
- Write (default parameters): bytes 34,12,05,80 -> oDevEnable=0001, oDevAddr=0x0005, oDevWData=0x1234, oDevWrite=1. iDevReady[0] high one cycle later -> oMISO sequence 01,00,00,00,00.
- Read with wait states: bytes 00,00,05,01; dev1 data 0xDEADBEEF, ready 3 cycles after enable -> enable high exactly 4 cycles, then oMISO 01,EF,BE,AD,DE.
- Timeout: read of 0x0200 with iDevReady=0 -> oDevEnable=0100 for exactly 255 cycles, then oMISO 02,00,00,00,00.
- Decode error and abort: read of 0x0400 -> status 04 with no enable. Separately, drop iSelect 2 cycles into a dev1 access -> enable low next cycle, IDLE, and the next frame behaves normally.
- Interrupts: pulse iDevIrq[2] -> oInterrupt=1 one cycle later. Read 0x7FFF -> 01,04,00,00,00 and oInterrupt=0 after the clear. Set and clear of bit 2 in the same cycle -> bit stays set.
- Reset mid-RESP: iRst for one cycle -> oReady=0, oMISO=0, pending=0, state IDLE.
